rpn_stack_calc: RTL
===================

# rpn_stack_calc

Parametrised reverse-Polish stack calculator: a `DEPTH`-entry, `W`-bit unsigned operand stack driven by one opcode per `apply` strobe. It adds stack-manipulation opcodes, a sticky error cause code and a `ready` handshake. Divide/modulo run on a multi-cycle restoring divider instead of a combinational one. It is the next-generation stack-arithmetic unit of the design and sits between an opcode/operand source and a result consumer reading `head`.

## Interface
- `W`, default 8: operand/result width, ≥ 2.
- `DEPTH`, default 10: stack entries, ≥ 2.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in` input W: operand for push.
- `op` input 4: opcode, sampled with `apply`.
- `apply` input 1: opcode strobe; accepted only when `ready`=1.
- `ready` output 1: high when a new opcode can be accepted.
- `head` output W: top of stack when size ≥ 1, else 0 (combinational from registered state).
- `size` output $clog2(DEPTH+1): current entry count.
- `empty` output 1: size == 0.
- `full` output 1: size == DEPTH.
- `valid` output 1: sticky OK flag; drops on any rejected opcode.
- `err` output 3: cause of the most recent rejection: 0 none, 1 overflow, 2 underflow, 3 divide-by-zero, 4 illegal opcode.

## Operation
- Opcodes (T = top, N = next):
  - 0 push `in`.
  - 1 pop.
  - 2 T+1.
  - 3 T−1.
  - 4 N+T.
  - 5 N−T.
  - 6 N*T.
  - 7 N/T.
  - 8 N%T.
  - 9 dup.
  - 10 swap.
  - 11 clear: size←0; `valid`/`err` unchanged.
  - 12 clear error: `valid`←1, `err`←0.
  - 13–15 illegal.
- Binary ops (4–8) replace N with the result and decrement size.
- Preconditions:
  - push/dup need size < DEPTH, else overflow.
  - Ops 1/2/3/9 need size ≥ 1; ops 4–8 and 10 need size ≥ 2; otherwise underflow.
  - Ops 7/8 with T == 0: divide-by-zero.
- A rejected opcode leaves stack and size unchanged, sets `valid`←0 and loads `err` with its cause. A later rejection overwrites `err`.
- Only rst or op 12 restore `valid`.
- Arithmetic is unsigned; results are truncated to the low W bits (wrap). Multiply keeps the low W bits of the 2W-bit product.
- FSM states:
  - IDLE (`ready`=1).
  - DIV (`ready`=0).
  - IDLE→DIV on an accepted, legal op 7/8. Operands are latched and the stack is untouched.
  - DIV runs exactly W restoring iterations, then writes quotient (op 7) or remainder (op 8) into N, decrements size and returns to IDLE.
- `apply` while `ready`=0 is ignored: no error, no state change.
- Stack storage is not reset. Entries above `size` are don't-care and are never visible on `head`.

## Timing
- Reset values:
  - size 0, `empty` 1, `full` 0, `head` 0.
  - `valid` 1, `err` 0, `ready` 1.
  - FSM in IDLE.
- Single-cycle ops: the edge that samples `apply`=1 updates stack, size and flags. New `head` is visible right after that edge (latency 1).
- Div/mod:
  - Accept at edge 0; `ready` is 0 after edge 0.
  - Iterations occur at edges 1..W.
  - Writeback occurs at edge W+1; `ready` is 1 and the result is on `head` after edge W+1.
  - Total latency W+1 cycles. `head` and `size` are stable at their pre-op values during DIV.
- Divide-by-zero and underflow on ops 7/8 are detected at accept. They take one cycle and never enter DIV.
- `rst` during DIV aborts the division: all outputs return to reset values on that edge.
- Back-to-back single-cycle ops are accepted every cycle. The next op after a div is accepted at the first edge where `ready`=1.

## Configuration
- `RPN_SAT_EN` defined: add, mul and inc saturate to 2^W−1; sub and dec saturate to 0. No error is flagged.
- `RPN_SAT_EN` undefined: all arithmetic wraps modulo 2^W.
- Div/mod, stack ops and error handling are identical in both builds.

## Test plan
All scenarios use W=8, DEPTH=4.
- Push 3, push 4, op 4 → `head`=7, `size`=1, `valid`=1, `err`=0.
- Push 200, push 100, op 4 → `head`=44 without `RPN_SAT_EN`, 255 with it. Push 5, push 9, op 5 → 252 / 0 respectively.
- Push 100, push 7, op 7:
  - `ready`=0 for 9 cycles; `apply` during that time is ignored.
  - Then `head`=14, `size`=1.
  - Repeat with op 8 → `head`=2.
- Pop on empty → `valid`=0, `err`=2, `size`=0. Op 12 → `valid`=1, `err`=0. Op 14 → `err`=4.
- Push 1,2,3,4 (`full`=1), then push 5 → `err`=1, `size`=4, `head`=4. Swap → `head`=3. Dup → `err`=1.
- Push 9, push 0, op 7 → `err`=3, `size`=2, no DIV entry. Push 9, push 3, op 7, assert `rst` at cycle 4 → `ready`=1, `size`=0, `valid`=1.

Source files
------------

// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc: reverse-Polish stack calculator with a DEPTH-entry, W-bit
// unsigned operand stack. One opcode is accepted per apply strobe while ready=1.
// Divide/modulo use a W-iteration restoring divider (ready=0 while it runs).
// Optional build macro: RPN_SAT_EN -- add/mul/inc saturate high, sub/dec saturate at 0.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in [W]          : push operand
//   op [4], apply   : opcode and its strobe
//   ready           : opcode can be accepted
//   head [W]        : top of stack (0 when empty)
//   size, empty, full : stack occupancy
//   valid, err [3]  : sticky OK flag and cause of most recent rejection
module rpn_stack_calc #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [W-1:0]                 in,
    input  logic [3:0]                   op,
    input  logic                         apply,
    output logic                         ready,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   size,
    output logic                         empty,
    output logic                         full,
    output logic                         valid,
    output logic [2:0]                   err
);

    localparam int unsigned SW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_OVF  = 3'd1;
    localparam logic [2:0] ERR_UNF  = 3'd2;
    localparam logic [2:0] ERR_DZ   = 3'd3;
    localparam logic [2:0] ERR_ILL  = 3'd4;

    typedef enum logic {ST_IDLE, ST_DIV} state_t;

    state_t         state, state_n;
    logic [W-1:0]   stk [DEPTH];
    logic [SW-1:0]  size_n;
    logic           valid_n;
    logic [2:0]     err_n;
    logic [W-1:0]   rem, rem_n, quo, quo_n, dvs, dvs_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           is_mod, is_mod_n;

    logic [AW-1:0]  tidx, nidx, pidx;
    logic [W-1:0]   t, n;
    logic           has1, has2;

    logic           we0, we1;
    logic [AW-1:0]  wa0, wa1;
    logic [W-1:0]   wd0, wd1;

    logic [W-1:0]   add_r, sub_r, mul_r, inc_r, dec_r;
    logic [W:0]     shifted, trial;
    logic           rej;
    logic [2:0]     cause;

    // Top, next and push slot indices; wrap when size is too small but never used then.
    assign tidx  = AW'(size - SW'(1));
    assign nidx  = AW'(size - SW'(2));
    assign pidx  = AW'(size);
    assign t     = stk[tidx];
    assign n     = stk[nidx];
    assign has1  = (size != SW'(0));
    assign has2  = (size >= SW'(2));

    assign empty = (size == SW'(0));
    assign full  = (size == SW'(DEPTH));
    assign ready = (state == ST_IDLE);
    assign head  = empty ? '0 : t;

    // Arithmetic results for single-cycle ops.
    always_comb begin
`ifdef RPN_SAT_EN
        logic [W:0]     add_w, inc_w;
        logic [2*W-1:0] mul_w;
        add_w = {1'b0, n} + {1'b0, t};
        inc_w = {1'b0, t} + (W+1)'(1);
        mul_w = (2*W)'(n) * (2*W)'(t);
        add_r = add_w[W] ? '1 : add_w[W-1:0];
        inc_r = inc_w[W] ? '1 : inc_w[W-1:0];
        mul_r = (mul_w[2*W-1:W] != '0) ? '1 : mul_w[W-1:0];
        sub_r = (n < t) ? '0 : W'(n - t);
        dec_r = (t == '0) ? '0 : W'(t - W'(1));
`else
        add_r = W'(n + t);
        inc_r = W'(t + W'(1));
        mul_r = W'(n * t);
        sub_r = W'(n - t);
        dec_r = W'(t - W'(1));
`endif
    end

    // One restoring step: shift in next dividend bit, subtract if it fits.
    assign shifted = {rem, quo[W-1]};
    assign trial   = shifted - {1'b0, dvs};

    // Next-state, stack write and flag logic.
    always_comb begin
        state_n  = state;
        size_n   = size;
        valid_n  = valid;
        err_n    = err;
        rem_n    = rem;
        quo_n    = quo;
        dvs_n    = dvs;
        cnt_n    = cnt;
        is_mod_n = is_mod;
        we0      = 1'b0;
        wa0      = tidx;
        wd0      = t;
        we1      = 1'b0;
        wa1      = nidx;
        wd1      = n;
        rej      = 1'b0;
        cause    = ERR_NONE;

        case (state)
            ST_IDLE: begin
                if (apply) begin
                    case (op)
                        4'd0: begin
                            if (full) begin rej = 1'b1; cause = ERR_OVF; end
                            else begin we0 = 1'b1; wa0 = pidx; wd0 = in; size_n = SW'(size + SW'(1)); end
                        end
                        4'd1: begin
                            if (!has1) begin rej = 1'b1; cause = ERR_UNF; end
                            else size_n = SW'(size - SW'(1));
                        end
                        4'd2, 4'd3: begin
                            if (!has1) begin rej = 1'b1; cause = ERR_UNF; end
                            else begin we0 = 1'b1; wd0 = (op == 4'd2) ? inc_r : dec_r; end
                        end
                        4'd4, 4'd5, 4'd6: begin
                            if (!has2) begin rej = 1'b1; cause = ERR_UNF; end
                            else begin
                                we0    = 1'b1;
                                wa0    = nidx;
                                wd0    = (op == 4'd4) ? add_r : (op == 4'd5) ? sub_r : mul_r;
                                size_n = SW'(size - SW'(1));
                            end
                        end
                        4'd7, 4'd8: begin
                            if (!has2) begin rej = 1'b1; cause = ERR_UNF; end
                            else if (t == '0) begin rej = 1'b1; cause = ERR_DZ; end
                            else begin
                                quo_n    = n;
                                rem_n    = '0;
                                dvs_n    = t;
                                cnt_n    = '0;
                                is_mod_n = (op == 4'd8);
                                state_n  = ST_DIV;
                            end
                        end
                        4'd9: begin
                            if (full) begin rej = 1'b1; cause = ERR_OVF; end
                            else if (!has1) begin rej = 1'b1; cause = ERR_UNF; end
                            else begin we0 = 1'b1; wa0 = pidx; wd0 = t; size_n = SW'(size + SW'(1)); end
                        end
                        4'd10: begin
                            if (!has2) begin rej = 1'b1; cause = ERR_UNF; end
                            else begin we0 = 1'b1; wd0 = n; we1 = 1'b1; wd1 = t; end
                        end
                        4'd11: size_n = '0;
                        4'd12: begin valid_n = 1'b1; err_n = ERR_NONE; end
                        default: begin rej = 1'b1; cause = ERR_ILL; end
                    endcase
                end
            end
            ST_DIV: begin
                if (cnt == CW'(W)) begin
                    we0     = 1'b1;
                    wa0     = nidx;
                    wd0     = is_mod ? rem : quo;
                    size_n  = SW'(size - SW'(1));
                    state_n = ST_IDLE;
                end else begin
                    if (!trial[W]) begin
                        rem_n = trial[W-1:0];
                        quo_n = {quo[W-2:0], 1'b1};
                    end else begin
                        rem_n = shifted[W-1:0];
                        quo_n = {quo[W-2:0], 1'b0};
                    end
                    cnt_n = CW'(cnt + CW'(1));
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (rej) begin
            valid_n = 1'b0;
            err_n   = cause;
        end
    end

    // Control and divider state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            size   <= '0;
            valid  <= 1'b1;
            err    <= ERR_NONE;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            is_mod <= 1'b0;
        end else begin
            state  <= state_n;
            size   <= size_n;
            valid  <= valid_n;
            err    <= err_n;
            rem    <= rem_n;
            quo    <= quo_n;
            dvs    <= dvs_n;
            cnt    <= cnt_n;
            is_mod <= is_mod_n;
        end
    end

    // Stack storage is not reset; only entries below size are ever observed.
    always_ff @(posedge clk) begin
        if (!rst && we0) stk[wa0] <= wd0;
        if (!rst && we1) stk[wa1] <= wd1;
    end

endmodule
